// File: rtl/button_debounce.sv
// -----------------------------------------------------------------------------
// button_debounce
//
// Conditions the raw push-button inputs of the lock front panel. Each button
// goes through a 2-flop synchroniser and then its own four-state debounce FSM.
// A new button state is accepted only after DEBOUNCE_CYCLES consecutive stable
// synchronised samples. The outputs are a clean registered level plus one-cycle
// registered press and release pulses.
//
// Channels are fully independent. Several press or release pulses may assert
// in the same cycle.
// -----------------------------------------------------------------------------
module button_debounce #(
    parameter int N_BTN           = 4,
    parameter int DEBOUNCE_CYCLES = 20,
    parameter int CNT_W           = 20
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release,
    output logic             any_pressed
);

    // Debounce states. The level is 1 in HELD and in ARM_RELEASE, so a
    // candidate release keeps reporting "pressed" until it is confirmed.
    typedef enum logic [1:0] {
        ST_IDLE        = 2'b00,
        ST_ARM_PRESS   = 2'b01,
        ST_HELD        = 2'b10,
        ST_ARM_RELEASE = 2'b11
    } state_e;

    // Terminal count. The counter stops here and never wraps, even when
    // DEBOUNCE_CYCLES equals 2^CNT_W.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    // Returns 1 for the states in which the debounced button reads pressed.
    function automatic logic level_of(input state_e st);
        logic lvl;
        case (st)
            ST_HELD:        lvl = 1'b1;
            ST_ARM_RELEASE: lvl = 1'b1;
            ST_IDLE:        lvl = 1'b0;
            ST_ARM_PRESS:   lvl = 1'b0;
            default:        lvl = 1'b0;
        endcase
        return lvl;
    endfunction

    // Two-stage synchroniser. sync2_q is the only view of btn_raw that the
    // debounce FSMs use.
    logic [N_BTN-1:0] sync1_q;
    logic [N_BTN-1:0] sync2_q;

    // Synchroniser flops: capture the asynchronous pins into the clk domain.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= {N_BTN{1'b0}};
            sync2_q <= {N_BTN{1'b0}};
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
        end
    end

    for (genvar g = 0; g < N_BTN; g++) begin : g_ch
        state_e           state_q;
        state_e           state_d;
        logic [CNT_W-1:0] cnt_q;
        logic [CNT_W-1:0] cnt_d;
        logic             level_q;
        logic             level_d;
        logic             press_q;
        logic             press_d;
        logic             rel_q;
        logic             rel_d;
        logic             s;

        assign s = sync2_q[g];

        // Next-state logic: debounce transitions, counter update and pulse decode.
        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            press_d = 1'b0;
            rel_d   = 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (s) begin
                        state_d = ST_ARM_PRESS;
                        cnt_d   = CNT_ZERO;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_ARM_PRESS: begin
                    if (!s) begin
                        // Bounce: the button went back low before it was
                        // stable for long enough. Drop it silently.
                        state_d = ST_IDLE;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d = ST_HELD;
                        press_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                ST_HELD: begin
                    if (!s) begin
                        state_d = ST_ARM_RELEASE;
                        cnt_d   = CNT_ZERO;
                    end else begin
                        state_d = ST_HELD;
                    end
                end
                ST_ARM_RELEASE: begin
                    if (s) begin
                        // Glitch low while held: return to HELD without a pulse.
                        state_d = ST_HELD;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d = ST_IDLE;
                        rel_d   = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = CNT_ZERO;
                end
            endcase
            level_d = level_of(state_d);
        end

        // State, counter and registered outputs of this channel.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                state_q <= ST_IDLE;
                cnt_q   <= CNT_ZERO;
                level_q <= 1'b0;
                press_q <= 1'b0;
                rel_q   <= 1'b0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                level_q <= level_d;
                press_q <= press_d;
                rel_q   <= rel_d;
            end
        end

        assign btn_level[g]   = level_q;
        assign btn_press[g]   = press_q;
        assign btn_release[g] = rel_q;
    end

    assign any_pressed = |btn_level;

endmodule
